// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM states, mode bits, default word width.
package spi_pkg;
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} spi_state_e;

   localparam logic CPOL      = 1'b0;
   localparam logic CPHA      = 1'b0;
   localparam int   DEF_WIDTH = 8;
endpackage

// File: rtl/spi_sync.sv
// 2-flop synchronizer followed by a history flop; edges compare the synced bit to its last value.
module spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic sys_clk,
   input  logic rstn,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);
   logic [2:0] sync_q;

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) sync_q <= {3{RST_VAL}};
      else       sync_q <= {sync_q[1:0], d_i};
   end

   assign sync_o = sync_q[1];
   assign rise_o =  sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] &  sync_q[2];
endmodule

// File: rtl/simple_spi_slave_rw.sv
// Mode-0 SPI slave, MSB first, oversampled on sys_clk; supports back-to-back words within one frame.
module simple_spi_slave_rw
   import spi_pkg::*;
#(
   parameter int reg_width = DEF_WIDTH
) (
   input  logic                 sys_clk,
   input  logic                 rstn,
   input  logic                 spi_clk,
   input  logic                 cs,
   input  logic                 mosi,
   output logic                 miso,
   input  logic [reg_width-1:0] tx_data,
   input  logic                 tx_load,
   output logic                 tx_taken,
   output logic [reg_width-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err
);
   localparam int CW = (reg_width > 2) ? $clog2(reg_width) : 1;
   localparam logic [CW-1:0] LAST = CW'(reg_width - 1);

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic unused_sync;

   spi_sync #(.RST_VAL(1'b0)) u_sclk (.sys_clk, .rstn, .d_i(spi_clk), .sync_o(sclk_s),
                                     .rise_o(sclk_rise), .fall_o(sclk_fall));
   spi_sync #(.RST_VAL(1'b1)) u_cs   (.sys_clk, .rstn, .d_i(cs), .sync_o(cs_s),
                                     .rise_o(cs_rise), .fall_o(cs_fall));
   spi_sync #(.RST_VAL(1'b0)) u_mosi (.sys_clk, .rstn, .d_i(mosi), .sync_o(mosi_s),
                                     .rise_o(mosi_rise), .fall_o(mosi_fall));

   assign unused_sync = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

   spi_state_e           state_q, state_d;
   logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [reg_width-1:0] rx_shift_q, rx_shift_d;
   logic [reg_width-1:0] tx_shift_q, tx_shift_d;
   logic [reg_width-1:0] tx_buf_q, tx_buf_d;
   logic [reg_width-1:0] rx_data_q, rx_data_d;
   logic                 miso_q, miso_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 tx_taken_q, tx_taken_d;
   logic                 frame_err_q, frame_err_d;
   // Set once a word completes so the next falling edge reloads instead of shifting.
   logic                 done_q, done_d;

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         tx_buf_q    <= '0;
         rx_data_q   <= '0;
         miso_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         tx_taken_q  <= 1'b0;
         frame_err_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         tx_buf_q    <= tx_buf_d;
         rx_data_q   <= rx_data_d;
         miso_q      <= miso_d;
         rx_valid_q  <= rx_valid_d;
         tx_taken_q  <= tx_taken_d;
         frame_err_q <= frame_err_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      rx_data_d   = rx_data_q;
      miso_d      = miso_q;
      rx_valid_d  = 1'b0;
      tx_taken_d  = 1'b0;
      frame_err_d = 1'b0;
      done_d      = done_q;
      // Reloads below read tx_buf_q, so a same-cycle load lands on the following word.
      tx_buf_d    = tx_load ? tx_data : tx_buf_q;

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d    = SHIFT;
               tx_shift_d = tx_buf_q;
               miso_d     = tx_buf_q[reg_width-1];
               bit_cnt_d  = '0;
               tx_taken_d = 1'b1;
               done_d     = 1'b0;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d     = IDLE;
               miso_d      = 1'b0;
               frame_err_d = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
               done_d      = 1'b0;
            end else if (sclk_rise) begin
               rx_shift_d = {rx_shift_q[reg_width-2:0], mosi_s};
               if (bit_cnt_q == LAST) begin
                  bit_cnt_d  = '0;
                  rx_data_d  = {rx_shift_q[reg_width-2:0], mosi_s};
                  rx_valid_d = 1'b1;
                  done_d     = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (sclk_fall) begin
               if (bit_cnt_q != '0) begin
                  tx_shift_d = {tx_shift_q[reg_width-2:0], 1'b0};
                  miso_d     = tx_shift_q[reg_width-2];
               end else if (done_q) begin
                  tx_shift_d = tx_buf_q;
                  miso_d     = tx_buf_q[reg_width-1];
                  tx_taken_d = 1'b1;
                  done_d     = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign miso      = miso_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign tx_taken  = tx_taken_q;
   assign frame_err = frame_err_q;
endmodule
